// File: rtl/vga_text_pkg.sv
// Shared types and default sizes for the VGA text pipeline.
// Used by the glyph serializer and the attribute-fetch stage.
package vga_text_pkg;

  localparam int GLYPH_W_DEF = 8;
  localparam int COLOR_W_DEF = 3;

  typedef enum logic {
    ST_BLANK,
    ST_ACTIVE
  } vga_state_e;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] fg;
    logic [COLOR_W_DEF-1:0] bg;
    logic                   inv;
  } glyph_attr_t;

endpackage

// File: rtl/glyph_hold_reg.sv
// Single-entry valid/ready holding register.
// A consume from downstream takes priority over a new load in the same cycle.
module glyph_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              consume,
  output logic              hold_valid,
  output logic [DATA_W-1:0] hold_data
);

  logic              hv_q, hv_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign in_ready   = !hv_q;
  assign hold_valid = hv_q;
  assign hold_data  = data_q;

  always_comb begin
    hv_d   = hv_q;
    data_d = data_q;
    if (consume) begin
      hv_d = 1'b0;
    end else if (in_valid && !hv_q) begin
      hv_d   = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_q   <= 1'b0;
      data_q <= '0;
    end else begin
      hv_q   <= hv_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/glyph_row_serializer.sv
// Double-buffered glyph row to colour pixel serializer with horizontal replication.
// Define GLYPH_GAP_EN for 9-column text cells (extra gap column after each glyph).
module glyph_row_serializer
  import vga_text_pkg::*;
#(
  parameter int GLYPH_W = GLYPH_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int SCALE_W = 2
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               display_area_enable,
  input  logic [GLYPH_W-1:0] glyph_row,
  input  logic [COLOR_W-1:0] glyph_fg,
  input  logic [COLOR_W-1:0] glyph_bg,
  input  logic               glyph_inv,
  input  logic               glyph_valid,
  output logic               glyph_ready,
  input  logic [SCALE_W-1:0] scale,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               pixel_on,
  output logic               underflow
);

  localparam int CNT_W   = $clog2(GLYPH_W + 1);
  localparam int ENTRY_W = GLYPH_W + 2 * COLOR_W + 1;
`ifdef GLYPH_GAP_EN
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(GLYPH_W);
`else
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(GLYPH_W - 1);
`endif
  localparam logic [GLYPH_W-1:0] MSB_MASK = {1'b1, {(GLYPH_W-1){1'b0}}};

  logic               hold_valid;
  logic [ENTRY_W-1:0] hold_data;
  logic               consume;

  glyph_hold_reg #(.DATA_W(ENTRY_W)) u_hold (
    .clk        (vga_clk),
    .rst_n      (reset_n),
    .in_valid   (glyph_valid),
    .in_data    ({glyph_row, glyph_fg, glyph_bg, glyph_inv}),
    .in_ready   (glyph_ready),
    .consume    (consume),
    .hold_valid (hold_valid),
    .hold_data  (hold_data)
  );

  vga_state_e         state_q, state_d;
  logic [GLYPH_W-1:0] shift_row_q, shift_row_d;
  logic [COLOR_W-1:0] shift_fg_q, shift_fg_d, shift_bg_q, shift_bg_d;
  logic               shift_inv_q, shift_inv_d, shift_valid_q, shift_valid_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SCALE_W-1:0] rep_cnt_q, rep_cnt_d, scale_q, scale_d;
  logic [COLOR_W-1:0] pixel_color_q, pixel_color_d;
  logic               pixel_on_q, pixel_on_d, underflow_q, underflow_d;

  logic [GLYPH_W-1:0] cur_row;
  logic [COLOR_W-1:0] cur_fg, cur_bg;
  logic               cur_inv, cur_valid, at_boundary, pix_bit;

  assign at_boundary = (state_q == ST_BLANK) || (bit_cnt_q == '0 && rep_cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    shift_row_d   = shift_row_q;
    shift_fg_d    = shift_fg_q;
    shift_bg_d    = shift_bg_q;
    shift_inv_d   = shift_inv_q;
    shift_valid_d = shift_valid_q;
    bit_cnt_d     = bit_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    scale_d       = scale_q;
    pixel_color_d = pixel_color_q;
    pixel_on_d    = pixel_on_q;
    underflow_d   = underflow_q;
    consume       = 1'b0;
    cur_row       = shift_row_q;
    cur_fg        = shift_fg_q;
    cur_bg        = shift_bg_q;
    cur_inv       = shift_inv_q;
    cur_valid     = shift_valid_q;
    pix_bit       = 1'b0;

    if (!display_area_enable) begin
      // Blanking drops the partial glyph but keeps the prefetched one.
      state_d       = ST_BLANK;
      bit_cnt_d     = '0;
      rep_cnt_d     = '0;
      scale_d       = scale;
      shift_valid_d = 1'b0;
      pixel_color_d = '0;
      pixel_on_d    = 1'b0;
    end else begin
      state_d = ST_ACTIVE;
      if (at_boundary) begin
        consume = hold_valid;
        {cur_row, cur_fg, cur_bg, cur_inv} = hold_data;
        cur_valid     = hold_valid;
        shift_row_d   = cur_row;
        shift_fg_d    = cur_fg;
        shift_bg_d    = cur_bg;
        shift_inv_d   = cur_inv;
        shift_valid_d = hold_valid;
        if (!hold_valid) underflow_d = 1'b1;
      end

      pix_bit = (|(cur_row & (MSB_MASK >> bit_cnt_q))) ^ cur_inv;
      if (!cur_valid) begin
        pixel_color_d = '0;
        pixel_on_d    = 1'b0;
`ifdef GLYPH_GAP_EN
      end else if (bit_cnt_q == BIT_LAST) begin
        pixel_color_d = cur_inv ? cur_fg : cur_bg;
        pixel_on_d    = 1'b0;
`endif
      end else begin
        pixel_color_d = pix_bit ? cur_fg : cur_bg;
        pixel_on_d    = pix_bit;
      end

      // Counters advance even in an empty slot so columns stay aligned.
      if (rep_cnt_q == scale_q) begin
        rep_cnt_d = '0;
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_BLANK;
      shift_row_q   <= '0;
      shift_fg_q    <= '0;
      shift_bg_q    <= '0;
      shift_inv_q   <= 1'b0;
      shift_valid_q <= 1'b0;
      bit_cnt_q     <= '0;
      rep_cnt_q     <= '0;
      scale_q       <= '0;
      pixel_color_q <= '0;
      pixel_on_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_row_q   <= shift_row_d;
      shift_fg_q    <= shift_fg_d;
      shift_bg_q    <= shift_bg_d;
      shift_inv_q   <= shift_inv_d;
      shift_valid_q <= shift_valid_d;
      bit_cnt_q     <= bit_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      scale_q       <= scale_d;
      pixel_color_q <= pixel_color_d;
      pixel_on_q    <= pixel_on_d;
      underflow_q   <= underflow_d;
    end
  end

  assign pixel_color = pixel_color_q;
  assign pixel_on    = pixel_on_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_glyph_row_serializer.sv
// Testbench for glyph_row_serializer: vector table, directed sequences and random
// traffic compared against a column-position reference model.
module tb_glyph_row_serializer;
  import vga_text_pkg::*;

  localparam int GW = GLYPH_W_DEF;
  localparam int CW = COLOR_W_DEF;
  localparam int SW = 2;
`ifdef GLYPH_GAP_EN
  localparam int CELL = GW + 1;
`else
  localparam int CELL = GW;
`endif

  logic          vga_clk = 1'b0;
  logic          reset_n;
  logic          display_area_enable;
  logic [GW-1:0] glyph_row;
  logic [CW-1:0] glyph_fg, glyph_bg;
  logic          glyph_inv, glyph_valid, glyph_ready;
  logic [SW-1:0] scale;
  logic [CW-1:0] pixel_color;
  logic          pixel_on, underflow;

  glyph_row_serializer #(.GLYPH_W(GW), .COLOR_W(CW), .SCALE_W(SW)) dut (
    .vga_clk             (vga_clk),
    .reset_n             (reset_n),
    .display_area_enable (display_area_enable),
    .glyph_row           (glyph_row),
    .glyph_fg            (glyph_fg),
    .glyph_bg            (glyph_bg),
    .glyph_inv           (glyph_inv),
    .glyph_valid         (glyph_valid),
    .glyph_ready         (glyph_ready),
    .scale               (scale),
    .pixel_color         (pixel_color),
    .pixel_on            (pixel_on),
    .underflow           (underflow)
  );

  always #5 vga_clk = ~vga_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: pixel position within the line decides slot and column.
  bit            m_hv;
  logic [GW-1:0] m_hold_row, m_cur_row;
  glyph_attr_t   m_hold_attr, m_cur_attr;
  bit            m_cur_v, m_uf, m_on;
  int            m_pos, m_scale;
  logic [CW-1:0] m_color;

  task automatic modelReset();
    m_hv = 0; m_cur_v = 0; m_uf = 0; m_on = 0; m_pos = 0; m_scale = 0;
    m_color = '0; m_hold_row = '0; m_cur_row = '0;
    m_hold_attr = '0; m_cur_attr = '0;
  endtask

  task automatic modelStep(input bit en, input bit valid, input logic [GW-1:0] row,
                           input logic [CW-1:0] fg, input logic [CW-1:0] bg,
                           input bit inv, input logic [SW-1:0] sc);
    bit rdy;
    bit take;
    bit b;
    int s, col;
    rdy  = !m_hv;
    take = 0;
    if (!en) begin
      m_on = 0; m_color = '0; m_pos = 0; m_scale = int'(sc); m_cur_v = 0;
    end else begin
      s = m_scale + 1;
      if (m_pos % (CELL * s) == 0) begin
        if (m_hv) begin
          m_cur_v = 1; m_cur_row = m_hold_row; m_cur_attr = m_hold_attr; take = 1;
        end else begin
          m_cur_v = 0; m_uf = 1;
        end
      end
      col = (m_pos / s) % CELL;
      if (!m_cur_v) begin
        m_on = 0; m_color = '0;
      end else if (col == GW) begin
        m_on = 0; m_color = m_cur_attr.inv ? m_cur_attr.fg : m_cur_attr.bg;
      end else begin
        b = m_cur_row[GW-1-col] ^ m_cur_attr.inv;
        m_on = b; m_color = b ? m_cur_attr.fg : m_cur_attr.bg;
      end
      m_pos++;
    end
    if (take) m_hv = 0;
    else if (valid && rdy) begin
      m_hv = 1; m_hold_row = row; m_hold_attr = '{fg: fg, bg: bg, inv: inv};
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit valid, input logic [GW-1:0] row,
                               input logic [CW-1:0] fg, input logic [CW-1:0] bg,
                               input bit inv, input logic [SW-1:0] sc);
    display_area_enable = en; glyph_valid = valid; glyph_row = row;
    glyph_fg = fg; glyph_bg = bg; glyph_inv = inv; scale = sc;
    @(posedge vga_clk);
    modelStep(en, valid, row, fg, bg, inv, sc);
    #1;
    checkOutput("pixel_color", int'(pixel_color), int'(m_color));
    checkOutput("pixel_on", int'(pixel_on), int'(m_on));
    checkOutput("underflow", int'(underflow), int'(m_uf));
    checkOutput("glyph_ready", int'(glyph_ready), int'(!m_hv));
  endtask

  typedef struct {
    bit            en;
    bit            valid;
    logic [GW-1:0] row;
    logic [CW-1:0] fg;
    logic [CW-1:0] bg;
    bit            inv;
    logic [SW-1:0] sc;
    bit            exp_on;
    logic [CW-1:0] exp_color;
    bit            exp_ready;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [GW-1:0] q[$];
    bit rdy, v, en;

    vecs[0] = '{1'b0, 1'b1, 8'hA5, 3'd7, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b1, 3'd7, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b1, 3'd7, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b1, 3'd7, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b1, 3'd7, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};

    reset_n = 1'b0; display_area_enable = 0; glyph_valid = 0; glyph_row = '0;
    glyph_fg = '0; glyph_bg = '0; glyph_inv = 0; scale = '0;
    modelReset();
    repeat (2) @(posedge vga_clk);
    #1;
    checkOutput("reset_color", int'(pixel_color), 0);
    checkOutput("reset_underflow", int'(underflow), 0);
    checkOutput("reset_ready", int'(glyph_ready), 1);
    @(negedge vga_clk);
    reset_n = 1'b1;

    // Basic shift of 8'hA5 from a blanking prefetch
    applyStimulus(0, 0, '0, '0, '0, 0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].row, vecs[i].fg, vecs[i].bg,
                    vecs[i].inv, vecs[i].sc);
      checkOutput($sformatf("vec%0d_on", i), int'(pixel_on), int'(vecs[i].exp_on));
      checkOutput($sformatf("vec%0d_color", i), int'(pixel_color), int'(vecs[i].exp_color));
      checkOutput($sformatf("vec%0d_ready", i), int'(glyph_ready), int'(vecs[i].exp_ready));
    end

    // Back-to-back glyphs with valid held high
    q = '{8'hF0, 8'h0F, 8'hFF};
    for (int c = 0; c < 25; c++) begin
      v = (q.size() > 0);
      rdy = glyph_ready;
      applyStimulus(c > 0, v, v ? q[0] : 8'h00, 3'd6, 3'd1, 0, 2'd0);
      if (v && rdy) void'(q.pop_front());
    end
    checkOutput("b2b_underflow", int'(underflow), 0);
    applyStimulus(0, 0, '0, '0, '0, 0, 2'd0);

    // Scale 2 with invert; a mid-line scale change must not take effect
    applyStimulus(0, 1, 8'h80, 3'd7, 3'd0, 1, 2'd1);
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1, 0, '0, '0, '0, 0, (c >= 5) ? 2'd3 : 2'd1);
      checkOutput($sformatf("inv_on%0d", c), int'(pixel_on), (c < 2) ? 0 : 1);
    end
    applyStimulus(0, 1, 8'h81, 3'd5, 3'd2, 0, 2'd3);
    for (int c = 0; c < 34; c++) applyStimulus(1, 0, '0, '0, '0, 0, 2'd0);
    applyStimulus(0, 0, '0, '0, '0, 0, 2'd0);

    // Underflow in the second slot, new glyph aligned to the third slot
    modelReset();
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    applyStimulus(0, 1, 8'hAA, 3'd3, 3'd4, 0, 2'd0);
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1, (c >= 9 && c < 12), 8'h3C, 3'd7, 3'd1, 0, 2'd0);
      if (c >= 8 && c < 16) checkOutput($sformatf("uf_slot_color%0d", c), int'(pixel_color), 0);
    end
    checkOutput("uf_sticky", int'(underflow), 1);
    applyStimulus(0, 0, '0, '0, '0, 0, 2'd0);
    checkOutput("uf_sticky_blank", int'(underflow), 1);

`ifdef GLYPH_GAP_EN
    // Gap column: bg for a normal glyph, fg for an inverted one
    applyStimulus(0, 1, 8'hFF, 3'd5, 3'd2, 0, 2'd0);
    for (int c = 0; c < 18; c++) begin
      applyStimulus(1, (c == 1), 8'hFF, 3'd5, 3'd2, 1, 2'd0);
      if (c == 8)  checkOutput("gap_bg", int'(pixel_color), 2);
      if (c == 17) checkOutput("gap_inv_fg", int'(pixel_color), 5);
    end
    applyStimulus(0, 0, '0, '0, '0, 0, 2'd0);
`endif

    // Randomised traffic
    en = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 29) == 0) en = !en;
      applyStimulus(en, $urandom_range(0, 3) != 0, GW'($urandom), CW'($urandom),
                    CW'($urandom), $urandom_range(0, 3) == 0, SW'($urandom));
    end

    // Asynchronous reset mid-active with a glyph held
    applyStimulus(0, 1, 8'hC3, 3'd7, 3'd0, 0, 2'd0);
    for (int c = 0; c < 3; c++) applyStimulus(1, 1, 8'h5A, 3'd7, 3'd0, 0, 2'd0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_color", int'(pixel_color), 0);
    checkOutput("async_rst_on", int'(pixel_on), 0);
    checkOutput("async_rst_underflow", int'(underflow), 0);
    checkOutput("async_rst_ready", int'(glyph_ready), 1);
    @(posedge vga_clk);
    #1;
    checkOutput("rst_hold_color", int'(pixel_color), 0);
    checkOutput("rst_hold_ready", int'(glyph_ready), 1);
    @(negedge vga_clk);
    reset_n = 1'b1;
    modelReset();
    applyStimulus(1, 0, '0, '0, '0, 0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
